// File: rtl/sys_defs.sv
// Shared bus definitions between the data cache and its memory-side responder.
package sys_defs;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } bus_command_t;

    localparam int unsigned TAG_W = 4;

endpackage

// File: rtl/mem_ret_pipe.sv
// Fixed-latency return delay line carrying {valid, tag, data} for accepted loads.
module mem_ret_pipe
    import sys_defs::*;
#(
    parameter int unsigned LATENCY = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [63:0]      in_data,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag,
    output logic [63:0]      out_data
);

    logic [LATENCY-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q  [LATENCY];
    logic [63:0]        data_q [LATENCY];

    // Shift every stage forward one slot per cycle; reset empties the whole line.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < int'(LATENCY); i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            tag_q[0]   <= in_tag;
            data_q[0]  <= in_data;
            for (int i = 1; i < int'(LATENCY); i++) begin
                valid_q[i] <= valid_q[i-1];
                tag_q[i]   <= tag_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_tag   = tag_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/dmem_responder.sv
// Data-side main-memory responder: grants tags, stores immediately, returns loads
// in order after a fixed latency.
module dmem_responder
    import sys_defs::*;
#(
    parameter int unsigned MEM_WORDS       = 1024,
    parameter int unsigned LATENCY         = 4,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       proc2mem_command,
    input  logic [63:0]      proc2mem_addr,
    input  logic [63:0]      proc2mem_data,
    output logic [TAG_W-1:0] mem2proc_response,
    output logic [63:0]      mem2proc_data,
    output logic [TAG_W-1:0] mem2proc_tag
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [63:0]      mem [MEM_WORDS];
    logic [IDX_W-1:0] word_idx;
    logic [63:0]      rd_data;
    logic [TAG_W-1:0] next_tag;
    logic [OUT_W-1:0] outstanding;
    logic             is_load, is_store;
    logic             load_accept, store_accept, any_accept;
    logic             ret_valid;
    logic [TAG_W-1:0] ret_tag;
    logic [63:0]      ret_data;
    logic             unused_addr_bits;

    // Byte offset and bits above the store depth are dropped so addresses wrap.
    assign word_idx         = proc2mem_addr[3 +: IDX_W];
    assign unused_addr_bits = ^{proc2mem_addr[2:0], proc2mem_addr[63:3+IDX_W]};
    assign rd_data          = mem[word_idx];

    // Decode the command and decide acceptance; a same-cycle return frees a slot.
    always_comb begin
        is_load      = (proc2mem_command == BUS_LOAD);
        is_store     = (proc2mem_command == BUS_STORE);
        load_accept  = !reset && is_load &&
                       ((outstanding < OUT_W'(MAX_OUTSTANDING)) || ret_valid);
        store_accept = !reset && is_store;
        any_accept   = load_accept || store_accept;
        mem2proc_response = any_accept ? next_tag : '0;
    end

    // Backing store write port; contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (store_accept) begin
            mem[word_idx] <= proc2mem_data;
        end
    end

    // Tag counter cycles 1..15, skipping 0 which means "not accepted".
    always_ff @(posedge clock) begin
        if (reset) begin
            next_tag <= TAG_W'(1);
        end else if (any_accept) begin
            next_tag <= (next_tag == TAG_W'(15)) ? TAG_W'(1) : next_tag + TAG_W'(1);
        end
    end

    // Loads in flight: accept and return in the same cycle cancel out.
    always_ff @(posedge clock) begin
        if (reset) begin
            outstanding <= '0;
        end else if (load_accept && !ret_valid) begin
            outstanding <= outstanding + OUT_W'(1);
        end else if (!load_accept && ret_valid) begin
            outstanding <= outstanding - OUT_W'(1);
        end
    end

    // Tag and data are zeroed when not accepted so idle slots drain as all-zero.
    mem_ret_pipe #(
        .LATENCY (LATENCY)
    ) u_ret_pipe (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (load_accept),
        .in_tag    (load_accept ? next_tag : '0),
        .in_data   (load_accept ? rd_data : 64'h0),
        .out_valid (ret_valid),
        .out_tag   (ret_tag),
        .out_data  (ret_data)
    );

    assign mem2proc_tag  = ret_tag;
    assign mem2proc_data = ret_data;

endmodule
